inst_fetch: RTL and testbench

Program-counter and fetch stage sitting directly upstream of the instruction ROM and downstream of nothing but reset: drives the ROM address, registers the returned 8-bit instruction for decode, and resolves label-based branches. After reset it pre-scans the ROM once to build a 15-entry label table from label-marker instructions (1111_xxxx), so forward branches resolve without software help. Halt (1110_0000) and the end-of-program sentinel (1111_1111) stop fetch until reset.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/label_table.sv | 42 ++++
 rtl/inst_fetch.sv | 113 +++++++++++
 tb/tb_inst_fetch.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and opcodes for the fetch stage and its label table.
package fetch_pkg;
  localparam int NUM_LABELS = 15;
  localparam int ADDR_W     = 8;

  typedef enum logic [1:0] {ST_SCAN, ST_IDLE, ST_RUN, ST_HALT} state_t;

  localparam logic [3:0] LABEL_MASK = 4'b1111;
  localparam logic [7:0] HALT_OP    = 8'hE0;
  localparam logic [7:0] SENTINEL   = 8'hFF;

  // 1111_1111 shares the marker nibble but is the end-of-program sentinel.
  function automatic logic is_label(input logic [7:0] instr);
    return (instr[7:4] == LABEL_MASK) && (instr[3:0] != LABEL_MASK);
  endfunction
endpackage

// File: rtl/label_table.sv
// Label index -> ROM address table, written during the pre-scan, read for branches.
module label_table
  import fetch_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [3:0]        wr_idx,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [3:0]        rd_idx,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic              dup
);
  logic [NUM_LABELS-1:0] valid_q;
  logic [ADDR_W-1:0]     addr_q [NUM_LABELS];
  logic [15:0]           valid_ext;
  logic                  wr_ok;
  logic                  wr_new;

  // Index 15 reads as permanently undefined.
  assign valid_ext = {1'b0, valid_q};
  assign wr_ok     = wr_en && (wr_idx != 4'hF);
  assign wr_new    = wr_ok && !valid_ext[wr_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dup     <= 1'b0;
    end else if (wr_ok) begin
      if (valid_ext[wr_idx]) dup <= 1'b1;
      else                   valid_q[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_new) addr_q[wr_idx] <= wr_addr;
  end

  assign rd_valid = valid_ext[rd_idx];
  assign rd_addr  = addr_q[rd_idx];
endmodule

// File: rtl/inst_fetch.sv
// Program counter / fetch stage: ROM label pre-scan, sequential fetch, label branches, halt.
module inst_fetch
  import fetch_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_n_i,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [7:0]        rom_data_i,
  input  logic              start_i,
  input  logic              stall_i,
  input  logic              branch_i,
  input  logic [3:0]        branch_label_i,
  output logic [7:0]        instr_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic              instr_valid_o,
  output logic              scan_done_o,
  output logic              halted_o,
  output logic              dup_label_o,
  output logic              bad_label_o
);
  state_t            state;
  logic [ADDR_W-1:0] scan_ptr;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] tbl_addr;
  logic              tbl_valid;
  logic              tbl_wr;

  assign tbl_wr = (state == ST_SCAN) && is_label(rom_data_i);

  label_table u_label_table (
    .clk      (clk_i),
    .rst_n    (rst_n_i),
    .wr_en    (tbl_wr),
    .wr_idx   (rom_data_i[3:0]),
    .wr_addr  (scan_ptr),
    .rd_idx   (branch_label_i),
    .rd_addr  (tbl_addr),
    .rd_valid (tbl_valid),
    .dup      (dup_label_o)
  );

  always_comb begin
    rom_addr_o = '0;
    case (state)
      ST_SCAN: rom_addr_o = scan_ptr;
      ST_IDLE: rom_addr_o = '0;
      default: rom_addr_o = pc;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state         <= ST_SCAN;
      scan_ptr      <= '0;
      pc            <= '0;
      instr_o       <= '0;
      pc_o          <= '0;
      instr_valid_o <= 1'b0;
      scan_done_o   <= 1'b0;
      halted_o      <= 1'b0;
      bad_label_o   <= 1'b0;
    end else begin
      case (state)
        ST_SCAN: begin
          scan_ptr <= scan_ptr + 1'b1;
          if (rom_data_i == SENTINEL || scan_ptr == '1) begin
            state       <= ST_IDLE;
            scan_done_o <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (start_i) begin
            pc    <= '0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          // A halt that has already been delivered retires before anything else.
          if (instr_valid_o && instr_o == HALT_OP) begin
            instr_valid_o <= 1'b0;
            halted_o      <= 1'b1;
            state         <= ST_HALT;
          end else if (branch_i) begin
            instr_valid_o <= 1'b0;
            if (tbl_valid) begin
              pc <= tbl_addr;
            end else begin
              bad_label_o <= 1'b1;
              halted_o    <= 1'b1;
              state       <= ST_HALT;
            end
          end else if (!stall_i) begin
            if (rom_data_i == SENTINEL) begin
              instr_valid_o <= 1'b0;
              halted_o      <= 1'b1;
              state         <= ST_HALT;
            end else begin
              instr_o       <= rom_data_i;
              pc_o          <= pc;
              instr_valid_o <= 1'b1;
              pc            <= pc + 1'b1;
            end
          end
        end
        ST_HALT: begin
          instr_valid_o <= 1'b0;
          halted_o      <= 1'b1;
        end
        default: state <= ST_SCAN;
      endcase
    end
  end
endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: vector table plus hand sequences for scan, stall, halt, wrap, reset.
module tb_inst_fetch;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] rom_addr, rom_data, instr, pc;
  logic       start, stall, branch;
  logic [3:0] lbl;
  logic       valid, scan_done, halted, dup, bad;
  logic [7:0] rom [256];
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;
  assign rom_data = rom[rom_addr];

  inst_fetch dut (
    .clk_i(clk), .rst_n_i(rst_n), .rom_addr_o(rom_addr), .rom_data_i(rom_data),
    .start_i(start), .stall_i(stall), .branch_i(branch), .branch_label_i(lbl),
    .instr_o(instr), .pc_o(pc), .instr_valid_o(valid), .scan_done_o(scan_done),
    .halted_o(halted), .dup_label_o(dup), .bad_label_o(bad)
  );

  typedef struct {
    logic       start, stall, branch;
    logic [3:0] lbl;
    logic       vld;
    logic [7:0] instr, pc;
    logic       halted, bad;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    start = 1'b0; stall = 1'b0; branch = 1'b0; lbl = 4'd0;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_chk(input string name, input logic [7:0] ei, input logic [7:0] ep);
    chk({name, ".valid"}, valid, 1);
    chk({name, ".instr"}, instr, ei);
    chk({name, ".pc"}, pc, ep);
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    #2;
    chk("rst.rom_addr", rom_addr, 0);
    chk("rst.instr", instr, 0);
    chk("rst.pc", pc, 0);
    chk("rst.valid", valid, 0);
    chk("rst.scan_done", scan_done, 0);
    chk("rst.halted", halted, 0);
    chk("rst.dup", dup, 0);
    chk("rst.bad", bad, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_scan(input int exp_cycles, input string name);
    int n = 0;
    while (!scan_done && n < 400) begin
      cycle();
      n++;
    end
    chk(name, n, exp_cycles);
  endtask

  task automatic load_rom_a();
    for (int i = 0; i < 256; i++) rom[i] = (i < 8'h3E) ? 8'(i) : 8'hFF;
    rom[8'h0B] = 8'hF0;
    rom[8'h25] = 8'hF1;
    rom[8'h38] = 8'hF8;
    rom[8'h3E] = 8'hE0;
  endtask

  initial begin
    idle_inputs();
    load_rom_a();

    // Sequential run of ROM A with a 3-cycle stall at 0x10, ending on the halt opcode.
    do_reset();
    wait_scan(64, "scanA.cycles");
    chk("scanA.dup", dup, 0);
    start = 1'b1; cycle(); start = 1'b0;
    chk("run.start_valid", valid, 0);
    for (int a = 0; a <= 8'h3E; a++) begin
      cycle();
      fetch_chk("run", rom[8'(a)], 8'(a));
      if (a == 16) begin
        stall = 1'b1;
        repeat (3) begin cycle(); fetch_chk("stall", 8'h10, 8'h10); end
        stall = 1'b0;
      end
    end
    cycle();
    chk("halt.valid", valid, 0);
    chk("halt.halted", halted, 1);
    start = 1'b1; cycle(); start = 1'b0;
    chk("halt.sticky", halted, 1);
    chk("halt.valid2", valid, 0);

    // Vector table: branches, stall+branch, run into halt, inputs ignored in HALT.
    vecs.push_back('{1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 8'h01, 8'h01, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 4'd1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 8'hF1, 8'h25, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 8'hF1, 8'h25, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 8'hF1, 8'h25, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 8'h26, 8'h26, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 8'hF0, 8'h0B, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 8'h0C, 8'h0C, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 4'd8, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 8'hF8, 8'h38, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 8'h39, 8'h39, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 8'h3A, 8'h3A, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 8'h3B, 8'h3B, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 8'h3C, 8'h3C, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 8'h3D, 8'h3D, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 8'hE0, 8'h3E, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 4'd1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0});
    do_reset();
    wait_scan(64, "scanB.cycles");
    for (int i = 0; i < vecs.size(); i++) begin
      start = vecs[i].start; stall = vecs[i].stall;
      branch = vecs[i].branch; lbl = vecs[i].lbl;
      cycle();
      chk($sformatf("vec%0d.valid", i), valid, vecs[i].vld);
      if (vecs[i].vld) begin
        chk($sformatf("vec%0d.instr", i), instr, vecs[i].instr);
        chk($sformatf("vec%0d.pc", i), pc, vecs[i].pc);
      end
      chk($sformatf("vec%0d.halted", i), halted, vecs[i].halted);
      chk($sformatf("vec%0d.bad", i), bad, vecs[i].bad);
    end
    idle_inputs();

    // Branch on the same edge that would fetch the halt opcode takes the branch.
    do_reset();
    wait_scan(64, "scanC.cycles");
    start = 1'b1; cycle(); start = 1'b0;
    branch = 1'b1; lbl = 4'd8; cycle(); branch = 1'b0;
    chk("hb.flush", valid, 0);
    for (int a = 8'h38; a <= 8'h3D; a++) begin cycle(); fetch_chk("hb.run", rom[8'(a)], 8'(a)); end
    branch = 1'b1; lbl = 4'd1; cycle(); branch = 1'b0;
    chk("hb.valid", valid, 0);
    chk("hb.not_halted", halted, 0);
    cycle();
    fetch_chk("hb.target", 8'hF1, 8'h25);
    chk("hb.halted_after", halted, 0);

    // Undefined label 5, then reserved label 15.
    do_reset();
    wait_scan(64, "scanD.cycles");
    start = 1'b1; cycle(); start = 1'b0;
    cycle(); fetch_chk("bad5.pre", 8'h00, 8'h00);
    branch = 1'b1; lbl = 4'd5; cycle(); branch = 1'b0;
    chk("bad5.bad", bad, 1);
    chk("bad5.halted", halted, 1);
    chk("bad5.valid", valid, 0);
    do_reset();
    wait_scan(64, "scanE.cycles");
    start = 1'b1; cycle(); start = 1'b0;
    branch = 1'b1; lbl = 4'd15; cycle(); branch = 1'b0;
    chk("bad15.bad", bad, 1);
    chk("bad15.halted", halted, 1);

    // Duplicate label 1 at 0x30; start pulsed during scan must be dropped.
    rom[8'h30] = 8'hF1;
    do_reset();
    start = 1'b1; repeat (3) cycle(); start = 1'b0;
    wait_scan(61, "scanF.cycles");
    chk("dup.flag", dup, 1);
    repeat (3) cycle();
    chk("scanstart.valid", valid, 0);
    chk("scanstart.addr", rom_addr, 0);
    start = 1'b1; cycle(); start = 1'b0;
    branch = 1'b1; lbl = 4'd1; cycle(); branch = 1'b0;
    cycle();
    fetch_chk("dup.first_kept", 8'hF1, 8'h25);

    // ROM without sentinel: full 256-address scan, PC wrap, reset mid-run.
    for (int i = 0; i < 256; i++) rom[i] = 8'(i & 8'h7F);
    do_reset();
    wait_scan(256, "scanG.cycles");
    start = 1'b1; cycle(); start = 1'b0;
    for (int k = 0; k < 300; k++) begin
      cycle();
      fetch_chk("wrap", rom[8'(k % 256)], 8'(k % 256));
    end
    do_reset();
    chk("rescan.addr0", rom_addr, 0);
    chk("rescan.done", scan_done, 0);
    cycle(); chk("rescan.addr1", rom_addr, 1);
    cycle(); chk("rescan.addr2", rom_addr, 2);
    chk("rescan.valid", valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
